fb_writer: RTL and testbench

- SRAM-side writer for the frame buffer; the write counterpart to the read-only frame-buffer scan-out path.
- Takes a rectangle request from the NIOS PIOs (startx, starty, sizex, sizey, start) and a 5-bit colour pixel stream.
- Writes one pixel per 16-bit SRAM word, row-major, at address y*H_RES + x.
- Owns the SRAM bus only while an external arbiter grants it; the scan-out reader holds it otherwise.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_writer_rect_walker.sv | 69 ++++++
 rtl/fb_writer.sv | 136 +++++++++++++
 tb/tb_fb_writer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, FSM state type and pixel-address helper for the
// frame-buffer writer (fb_writer) and its rectangle walker.
package fb_pkg;

   localparam int H_RES   = 640;
   localparam int V_RES   = 480;
   localparam int ADDR_W  = 20;
   localparam int COLOR_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      WRITE,
      HOLD,
      ADV,
      DONE
   } fb_wr_state_t;

   // Linear word address of pixel (x, y) in the row-major frame buffer.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
      return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/fb_writer_rect_walker.sv
// rect_walker: holds the latched rectangle geometry and walks it row-major,
// producing the current word address plus clip and last-pixel flags.
module rect_walker
   import fb_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              launch,
   input  logic              advance,
   input  logic [9:0]        startx,
   input  logic [9:0]        starty,
   input  logic [9:0]        sizex,
   input  logic [9:0]        sizey,
   output logic [ADDR_W-1:0] addr,
   output logic              clip,
   output logic              last
);

   logic [9:0]        startx_q, starty_q, sizex_q, sizey_q;
   logic [9:0]        xcnt, ycnt;
   logic [ADDR_W-1:0] row_base;
   logic              x_end, y_end;
   logic [10:0]       xpos, ypos;

   // Geometry is data only: captured at launch, no reset needed.
   always_ff @(posedge Clk) begin
      if (launch) begin
         startx_q <= startx;
         starty_q <= starty;
         sizex_q  <= sizex;
         sizey_q  <= sizey;
      end
   end

   // Row-major walk; counters hold on the final pixel instead of wrapping.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         xcnt     <= '0;
         ycnt     <= '0;
         row_base <= '0;
      end else if (launch) begin
         xcnt     <= '0;
         ycnt     <= '0;
         row_base <= pix_addr(startx, starty);
      end else if (advance) begin
         if (x_end) begin
            if (!y_end) begin
               xcnt     <= '0;
               ycnt     <= ycnt + 10'd1;
               row_base <= row_base + ADDR_W'(H_RES);
            end
         end else begin
            xcnt <= xcnt + 10'd1;
         end
      end
   end

   assign x_end = (xcnt == sizex_q - 10'd1);
   assign y_end = (ycnt == sizey_q - 10'd1);
   assign last  = x_end & y_end;

   // One extra bit so positions past the right/bottom edge do not alias.
   assign xpos = {1'b0, startx_q} + {1'b0, xcnt};
   assign ypos = {1'b0, starty_q} + {1'b0, ycnt};
   assign clip = (xpos >= 11'(H_RES)) | (ypos >= 11'(V_RES));

   assign addr = row_base + ADDR_W'(xcnt);

endmodule

// File: rtl/fb_writer.sv
// fb_writer: SRAM-side rectangle writer for the frame buffer. One pixel per
// 16-bit word, row-major; owns the bus only while sram_grant is high.
// Optional constant-colour fill mode is enabled by defining FB_WRITER_FILL_EN.
module fb_writer
   import fb_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
`ifdef FB_WRITER_FILL_EN
   input  logic               fill_en,
   input  logic [COLOR_W-1:0] fill_color,
`endif
   input  logic               start,
   input  logic [9:0]         startx,
   input  logic [9:0]         starty,
   input  logic [9:0]         sizex,
   input  logic [9:0]         sizey,
   input  logic [COLOR_W-1:0] px_data,
   input  logic               px_valid,
   output logic               px_ready,
   input  logic               sram_grant,
   output logic               sram_req,
   output logic [ADDR_W-1:0]  sram_addr,
   output logic [15:0]        sram_wdata,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               busy,
   output logic               done
);

   fb_wr_state_t       state;
   logic               start_q;
   logic               launch, advance, transfer;
   logic               fill_q;
   logic [COLOR_W-1:0] fill_color_q;
   logic [COLOR_W-1:0] pix;
   logic [ADDR_W-1:0]  walk_addr;
   logic               walk_clip, walk_last;

`ifdef FB_WRITER_FILL_EN
   // Fill mode and colour are captured together with the rectangle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fill_q       <= 1'b0;
         fill_color_q <= '0;
      end else if (launch) begin
         fill_q       <= fill_en;
         fill_color_q <= fill_color;
      end
   end
`else
   assign fill_q       = 1'b0;
   assign fill_color_q = '0;
`endif

   assign launch   = (state == IDLE) & start & ~start_q;
   assign advance  = (state == ADV);
   // Ready follows the grant combinationally so a revoked grant stalls at once.
   assign px_ready = (state == ACCEPT) & sram_grant & ~fill_q;
   assign transfer = (state == ACCEPT) & sram_grant & (fill_q | px_valid);
   assign pix      = fill_q ? fill_color_q : px_data;

   rect_walker u_walker (
      .Clk     (Clk),
      .Reset   (Reset),
      .launch  (launch),
      .advance (advance),
      .startx  (startx),
      .starty  (starty),
      .sizex   (sizex),
      .sizey   (sizey),
      .addr    (walk_addr),
      .clip    (walk_clip),
      .last    (walk_last)
   );

   // Write FSM: ACCEPT -> WRITE -> HOLD -> ADV per pixel, ACCEPT -> ADV when clipped.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_dq_oe <= 1'b0;
         sram_we_n  <= 1'b1;
         sram_req   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            IDLE: begin
               if (launch) begin
                  done     <= 1'b0;
                  busy     <= 1'b1;
                  sram_req <= 1'b1;
                  state    <= (sizex == 10'd0 || sizey == 10'd0) ? DONE : ACCEPT;
               end
            end
            ACCEPT: begin
               if (transfer) begin
                  sram_addr  <= walk_addr;
                  sram_wdata <= {{(16-COLOR_W){1'b0}}, pix};
                  if (walk_clip) begin
                     state <= ADV;
                  end else begin
                     // we_n and dq_oe assert together so we_n is never low with the bus floating.
                     sram_dq_oe <= 1'b1;
                     sram_we_n  <= 1'b0;
                     state      <= WRITE;
                  end
               end
            end
            WRITE: begin
               sram_we_n <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               state <= ADV;
            end
            ADV: begin
               sram_dq_oe <= 1'b0;
               state      <= walk_last ? DONE : ACCEPT;
            end
            DONE: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               sram_req <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: directed bench for fb_writer with a pixel-stream driver and a
// write monitor; define FB_WRITER_FILL_EN to also exercise fill mode.
module tb_fb_writer;
   import fb_pkg::*;

   logic               Clk;
   logic               Reset;
`ifdef FB_WRITER_FILL_EN
   logic               fill_en;
   logic [COLOR_W-1:0] fill_color;
`endif
   logic               start;
   logic [9:0]         startx, starty, sizex, sizey;
   logic [COLOR_W-1:0] px_data;
   logic               px_valid;
   logic               px_ready;
   logic               sram_grant;
   logic               sram_req;
   logic [ADDR_W-1:0]  sram_addr;
   logic [15:0]        sram_wdata;
   logic               sram_dq_oe;
   logic               sram_we_n;
   logic               busy;
   logic               done;

   int tests_run = 0;
   int tests_failed = 0;

   int cyc = 0;
   int wr_cnt = 0;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];
   int consumed = 0;
   int rdy_cnt = 0;
   int rdy_nogrant = 0;
   int we_long = 0;
   int oe_bad = 0;
   int done_rise = -1;
   int xfer_cyc = -1;
   int start_cyc = 0;
   int stream_left = 0;
   int stream_col = 0;
   int grant_off = 0;
   bit take = 1'b0;
   bit prev_we_low = 1'b0;
   bit prev_done = 1'b0;
   bit drop_arm = 1'b0;

   fb_writer dut (
      .Clk        (Clk),
      .Reset      (Reset),
`ifdef FB_WRITER_FILL_EN
      .fill_en    (fill_en),
      .fill_color (fill_color),
`endif
      .start      (start),
      .startx     (startx),
      .starty     (starty),
      .sizex      (sizex),
      .sizey      (sizey),
      .px_data    (px_data),
      .px_valid   (px_valid),
      .px_ready   (px_ready),
      .sram_grant (sram_grant),
      .sram_req   (sram_req),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_dq_oe (sram_dq_oe),
      .sram_we_n  (sram_we_n),
      .busy       (busy),
      .done       (done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // One clock: observe at the falling edge, then update stimulus just after the rising edge.
   task automatic tick();
      @(negedge Clk);
      if (!sram_we_n) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = 32'(sram_addr);
            wr_data[wr_cnt] = 32'(sram_wdata);
         end
         wr_cnt++;
         if (!sram_dq_oe) oe_bad++;
         if (prev_we_low) we_long++;
      end
      prev_we_low = !sram_we_n;
      if (px_ready) rdy_cnt++;
      if (px_ready && !sram_grant) rdy_nogrant++;
      if (done && !prev_done && done_rise < 0) done_rise = cyc;
      prev_done = done;
      take = px_valid & px_ready;
      if (take) begin
         consumed++;
         if (xfer_cyc < 0) xfer_cyc = cyc + 1;
         if (drop_arm) begin
            drop_arm  = 1'b0;
            grant_off = 5;
         end
      end
      @(posedge Clk);
      cyc++;
      #1;
      if (take) begin
         stream_col++;
         stream_left--;
      end
      px_valid = (stream_left > 0);
      px_data  = COLOR_W'(stream_col);
      if (grant_off > 0) begin
         sram_grant = 1'b0;
         grant_off--;
      end else begin
         sram_grant = 1'b1;
      end
   endtask

   task automatic launch(input int sx, input int sy, input int zx, input int zy);
      startx    = 10'(sx);
      starty    = 10'(sy);
      sizex     = 10'(zx);
      sizey     = 10'(zy);
      done_rise = -1;
      xfer_cyc  = -1;
      start_cyc = cyc;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done_rise < 0 && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done_rise >= 0), 32'd1);
   endtask

   task automatic chk_wr(input string tag, input int idx, input int a, input int d);
      chk({tag, "_present"}, 32'(idx < wr_cnt), 32'd1);
      if (idx < wr_cnt && idx < 64) begin
         chk({tag, "_addr"}, wr_addr[idx], 32'(a));
         chk({tag, "_data"}, wr_data[idx], 32'(d));
      end
   endtask

   initial begin
      int base, cons0, rdy0, n;

      Reset      = 1'b1;
      start      = 1'b0;
      startx     = '0;
      starty     = '0;
      sizex      = '0;
      sizey      = '0;
      px_data    = '0;
      px_valid   = 1'b0;
      sram_grant = 1'b1;
`ifdef FB_WRITER_FILL_EN
      fill_en    = 1'b0;
      fill_color = '0;
`endif
      #1;
      chk("rst_we_n",  32'(sram_we_n), 32'd1);
      chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_req",   32'(sram_req), 32'd0);
      chk("rst_ready", 32'(px_ready), 32'd0);
      chk("rst_addr",  32'(sram_addr), 32'd0);
      chk("rst_wdata", 32'(sram_wdata), 32'd0);
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      repeat (2) tick();

      // Basic 3x2 at (10,2), colours 1..6.
      base = wr_cnt; cons0 = consumed; we_long = 0; oe_bad = 0;
      stream_col = 1; stream_left = 6;
      launch(10, 2, 3, 2);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_req",  32'(sram_req), 32'd1);
      wait_done("t1", 200);
      chk("t1_wcount", 32'(wr_cnt - base), 32'd6);
      chk_wr("t1_w0", base + 0, 1290, 1);
      chk_wr("t1_w1", base + 1, 1291, 2);
      chk_wr("t1_w2", base + 2, 1292, 3);
      chk_wr("t1_w3", base + 3, 1930, 4);
      chk_wr("t1_w4", base + 4, 1931, 5);
      chk_wr("t1_w5", base + 5, 1932, 6);
      chk("t1_we_one_cycle", 32'(we_long), 32'd0);
      chk("t1_we_oe", 32'(oe_bad), 32'd0);
      chk("t1_consumed", 32'(consumed - cons0), 32'd6);
      chk("t1_latency", 32'(done_rise - xfer_cyc), 32'd24);
      repeat (3) tick();
      chk("t1_done_level", 32'(done), 32'd1);
      chk("t1_busy_off", 32'(busy), 32'd0);
      chk("t1_req_off", 32'(sram_req), 32'd0);

      // Bottom-right corner 4x2 at (638,479): only two pixels land on screen.
      base = wr_cnt; cons0 = consumed; we_long = 0; oe_bad = 0;
      stream_col = 10; stream_left = 8;
      launch(638, 479, 4, 2);
      wait_done("t2", 200);
      chk("t2_consumed", 32'(consumed - cons0), 32'd8);
      chk("t2_wcount", 32'(wr_cnt - base), 32'd2);
      chk_wr("t2_w0", base + 0, 307198, 10);
      chk_wr("t2_w1", base + 1, 307199, 11);
      chk("t2_latency", 32'(done_rise - xfer_cyc), 32'd20);
      chk("t2_we_oe", 32'(oe_bad), 32'd0);
      repeat (2) tick();

      // Zero width: immediate completion, stream untouched.
      base = wr_cnt; cons0 = consumed; rdy0 = rdy_cnt;
      stream_col = 3; stream_left = 2;
      launch(5, 5, 0, 3);
      wait_done("t3", 20);
      chk("t3_latency", 32'(done_rise - start_cyc), 32'd2);
      chk("t3_no_ready", 32'(rdy_cnt - rdy0), 32'd0);
      chk("t3_no_write", 32'(wr_cnt - base), 32'd0);
      chk("t3_consumed", 32'(consumed - cons0), 32'd0);
      stream_left = 0;
      repeat (2) tick();

      // Grant revoked right after the first transfer of a 3x1 at (0,5).
      base = wr_cnt; cons0 = consumed; rdy_nogrant = 0; we_long = 0;
      stream_col = 7; stream_left = 3; drop_arm = 1'b1;
      launch(0, 5, 3, 1);
      wait_done("t4", 200);
      chk("t4_wcount", 32'(wr_cnt - base), 32'd3);
      chk_wr("t4_w0", base + 0, 3200, 7);
      chk_wr("t4_w1", base + 1, 3201, 8);
      chk_wr("t4_w2", base + 2, 3202, 9);
      chk("t4_consumed", 32'(consumed - cons0), 32'd3);
      chk("t4_ready_no_grant", 32'(rdy_nogrant), 32'd0);
      chk("t4_latency", 32'(done_rise - xfer_cyc), 32'd14);
      chk("t4_we_one_cycle", 32'(we_long), 32'd0);
      repeat (2) tick();

      // Reset in the middle of a write, then a fresh 1x1 at (7,3).
      stream_col = 20; stream_left = 2;
      launch(4, 1, 2, 1);
      n = 0;
      while (!take && n < 50) begin
         tick();
         n++;
      end
      chk("t5_xfer_seen", 32'(take), 32'd1);
      chk("t5_pre_we_n", 32'(sram_we_n), 32'd0);
      #2;
      Reset = 1'b1;
      #1;
      chk("t5_rst_we_n",  32'(sram_we_n), 32'd1);
      chk("t5_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("t5_rst_busy",  32'(busy), 32'd0);
      chk("t5_rst_done",  32'(done), 32'd0);
      chk("t5_rst_ready", 32'(px_ready), 32'd0);
      stream_left = 0;
      px_valid = 1'b0;
      @(posedge Clk);
      cyc++;
      #1;
      Reset = 1'b0;
      prev_we_low = 1'b0;
      tick();
      base = wr_cnt;
      stream_col = 25; stream_left = 1;
      launch(7, 3, 1, 1);
      wait_done("t5", 100);
      chk("t5_wcount", 32'(wr_cnt - base), 32'd1);
      chk_wr("t5_w0", base + 0, 1927, 25);
      chk("t5_latency", 32'(done_rise - xfer_cyc), 32'd4);
      repeat (2) tick();

`ifdef FB_WRITER_FILL_EN
      // Fill 2x2 at (0,0) with 5'h1F while a stream is offered and ignored.
      base = wr_cnt; cons0 = consumed; rdy0 = rdy_cnt;
      fill_en = 1'b1; fill_color = 5'h1F;
      stream_col = 2; stream_left = 4;
      launch(0, 0, 2, 2);
      fill_en = 1'b0;
      wait_done("t6", 200);
      chk("t6_wcount", 32'(wr_cnt - base), 32'd4);
      chk_wr("t6_w0", base + 0, 0, 32'h1F);
      chk_wr("t6_w1", base + 1, 1, 32'h1F);
      chk_wr("t6_w2", base + 2, 640, 32'h1F);
      chk_wr("t6_w3", base + 3, 641, 32'h1F);
      chk("t6_no_ready", 32'(rdy_cnt - rdy0), 32'd0);
      chk("t6_consumed", 32'(consumed - cons0), 32'd0);
      stream_left = 0;
      repeat (2) tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
